// File: rtl/vgroup_pkg.sv
// Shared LMUL encodings, sequencer state type and the LMUL-to-group-count decode.
package vgroup_pkg;

  localparam logic [2:0] LMUL_1 = 3'b000;
  localparam logic [2:0] LMUL_2 = 3'b001;
  localparam logic [2:0] LMUL_4 = 3'b010;
  localparam logic [2:0] LMUL_8 = 3'b011;

  typedef enum logic {IDLE, ISSUE} state_t;

  // Registers per group; 0 marks a reserved encoding.
  function automatic logic [3:0] lmul_count(input logic [2:0] lmul);
    case (lmul)
      LMUL_1:  return 4'd1;
      LMUL_2:  return 4'd2;
      LMUL_4:  return 4'd4;
      LMUL_8:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/vgroup_lmul_decode.sv
// Capture-time decode: final group index (n-1) and, with VGROUP_ALIGN_CHECK_EN,
// a drop flag for reserved LMUL or bases not aligned to the group size.
module vgroup_lmul_decode
  import vgroup_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 3
) (
  input  logic [2:0]        lmul,
  input  logic              group_en,
  input  logic [REG_AW-1:0] ra_a,
  input  logic [REG_AW-1:0] ra_b,
  input  logic [REG_AW-1:0] rdest,
  output logic [CNT_W-1:0]  last_idx,
  output logic              drop
);

  logic [3:0] cnt;

  always_comb begin
    cnt      = lmul_count(lmul);
    last_idx = '0;
    if (group_en && cnt != 4'd0) last_idx = CNT_W'(cnt - 4'd1);
  end

`ifdef VGROUP_ALIGN_CHECK_EN
  // n is a power of two, so n-1 masks the bits that must be zero.
  logic [REG_AW-1:0] mask;
  assign mask = REG_AW'(last_idx);
  assign drop = group_en && ((cnt == 4'd0) || (|((ra_a | ra_b | rdest) & mask)));
`else
  logic unused_bases;
  assign unused_bases = ^{ra_a, ra_b, rdest};
  assign drop = 1'b0;
`endif

endmodule

// File: rtl/vgroup_sequencer.sv
// Expands one decoded vector instruction into LMUL micro-ops and stalls fetch
// while a group is in flight. Optional macro: VGROUP_ALIGN_CHECK_EN.
module vgroup_sequencer
  import vgroup_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int OP_W   = 8,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_AW-1:0] in_raA,
  input  logic [REG_AW-1:0] in_raB,
  input  logic [REG_AW-1:0] in_rdest,
  input  logic [2:0]        in_lmul,
  input  logic              in_group_en,
  output logic              uop_valid,
  input  logic              uop_ready,
  output logic [OP_W-1:0]   uop_op,
  output logic [REG_AW-1:0] uop_raA,
  output logic [REG_AW-1:0] uop_raB,
  output logic [REG_AW-1:0] uop_rdest,
  output logic [CNT_W-1:0]  uop_idx,
  output logic              uop_last,
  output logic              stall_fetch,
  output logic              illegal
);

  state_t            state;
  logic [OP_W-1:0]   op_q;
  logic [REG_AW-1:0] ra_a_q, ra_b_q, rdest_q;
  logic [CNT_W-1:0]  idx, tgt;
  logic [CNT_W-1:0]  dec_last;
  logic              dec_drop;
  logic              accept, capture, done;

  vgroup_lmul_decode #(.REG_AW(REG_AW), .CNT_W(CNT_W)) u_dec (
    .lmul     (in_lmul),
    .group_en (in_group_en),
    .ra_a     (in_raA),
    .ra_b     (in_raB),
    .rdest    (in_rdest),
    .last_idx (dec_last),
    .drop     (dec_drop)
  );

  assign uop_last = uop_valid && (idx == tgt);
  assign accept   = uop_valid && uop_ready;
  assign done     = accept && uop_last;
  assign in_ready = (state == IDLE) || done;
  assign capture  = in_valid && in_ready;

  // In IDLE the stall rises in the capture cycle so IF sees it before the group starts.
  assign stall_fetch = (state == ISSUE) ? !done
                                        : (capture && !dec_drop && dec_last != '0);

  assign uop_op    = op_q;
  assign uop_idx   = idx;
  assign uop_raA   = ra_a_q  + REG_AW'(idx);
  assign uop_raB   = ra_b_q  + REG_AW'(idx);
  assign uop_rdest = rdest_q + REG_AW'(idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      uop_valid <= 1'b0;
      idx       <= '0;
      tgt       <= '0;
      op_q      <= '0;
      ra_a_q    <= '0;
      ra_b_q    <= '0;
      rdest_q   <= '0;
    end else if (capture && !dec_drop) begin
      state     <= ISSUE;
      uop_valid <= 1'b1;
      idx       <= '0;
      tgt       <= dec_last;
      op_q      <= in_op;
      ra_a_q    <= in_raA;
      ra_b_q    <= in_raB;
      rdest_q   <= in_rdest;
    end else if (accept) begin
      if (uop_last) begin
        state     <= IDLE;
        uop_valid <= 1'b0;
        idx       <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

`ifdef VGROUP_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) illegal <= 1'b0;
    else     illegal <= capture && dec_drop;
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_vgroup_sequencer.sv
// Directed scenarios plus a randomized run checked against a queue-of-micro-ops model.
module tb_vgroup_sequencer;

  logic       clk, rst;
  logic       in_valid, in_ready, in_group_en;
  logic [7:0] in_op;
  logic [4:0] in_raA, in_raB, in_rdest;
  logic [2:0] in_lmul;
  logic       uop_valid, uop_ready, uop_last, stall_fetch, illegal;
  logic [7:0] uop_op;
  logic [4:0] uop_raA, uop_raB, uop_rdest;
  logic [2:0] uop_idx;

  vgroup_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_raA(in_raA), .in_raB(in_raB), .in_rdest(in_rdest), .in_lmul(in_lmul),
    .in_group_en(in_group_en), .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_op(uop_op), .uop_raA(uop_raA), .uop_raB(uop_raB), .uop_rdest(uop_rdest),
    .uop_idx(uop_idx), .uop_last(uop_last), .stall_fetch(stall_fetch), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] op;
    logic [4:0] a, b, d;
    logic [2:0] idx;
    logic       last;
  } uop_t;

  uop_t q[$];
  logic exp_illegal;
  bit   last_take;
  int   n_checks, n_fail;

  function automatic int model_n(logic [2:0] lmul, logic gen);
    if (!gen) return 1;
    case (lmul)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      3'd3: return 8;
      default: return 1;
    endcase
  endfunction

  function automatic bit model_drop(logic [2:0] lmul, logic gen, logic [4:0] a, logic [4:0] b, logic [4:0] d);
`ifdef VGROUP_ALIGN_CHECK_EN
    int n;
    if (!gen) return 0;
    if (lmul[2]) return 1;
    n = model_n(lmul, gen);
    return (n > 1) && ((int'(a) % n != 0) || (int'(b) % n != 0) || (int'(d) % n != 0));
`else
    return 0;
`endif
  endfunction

  function automatic bit exp_in_ready();
    return (q.size() == 0) || (q.size() == 1 && uop_ready);
  endfunction

  function automatic bit exp_stall();
    if (q.size() > 0) return !(q.size() == 1 && uop_ready);
    return in_valid && !model_drop(in_lmul, in_group_en, in_raA, in_raB, in_rdest)
           && model_n(in_lmul, in_group_en) > 1;
  endfunction

  // Advance one clock and update the model from the inputs presented this cycle.
  task automatic step();
    bit take, pop, drp;
    int n;
    logic [7:0] op;
    logic [4:0] a, b, d;
    n   = model_n(in_lmul, in_group_en);
    drp = model_drop(in_lmul, in_group_en, in_raA, in_raB, in_rdest);
    take = in_valid && exp_in_ready();
    pop  = (q.size() > 0) && uop_ready;
    op = in_op; a = in_raA; b = in_raB; d = in_rdest;
    @(posedge clk);
    #1;
    last_take = take;
    if (rst) begin
      q.delete();
      exp_illegal = 1'b0;
      return;
    end
    if (pop) void'(q.pop_front());
    exp_illegal = take && drp;
    if (take && !drp)
      for (int i = 0; i < n; i++) begin
        uop_t u;
        u.op = op;
        u.a = 5'(int'(a) + i);
        u.b = 5'(int'(b) + i);
        u.d = 5'(int'(d) + i);
        u.idx = 3'(i);
        u.last = (i == n - 1);
        q.push_back(u);
      end
  endtask

  task automatic drive(logic v, logic [2:0] lmul, logic [4:0] a, logic [4:0] b, logic [4:0] d);
    in_valid = v; in_lmul = lmul; in_group_en = 1'b1;
    in_raA = a; in_raB = b; in_rdest = d; in_op = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
    uop_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    #2;
    n_checks++;
    if ({uop_valid, uop_idx, uop_last, stall_fetch, illegal, in_ready} !== {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_ctrl: got v=%b idx=%0d last=%b stall=%b ill=%b rdy=%b, want 0 0 0 0 0 1",
               uop_valid, uop_idx, uop_last, stall_fetch, illegal, in_ready);
    end
    n_checks++;
    if ({uop_op, uop_raA, uop_raB, uop_rdest} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_data: got op=%h a=%0d b=%0d d=%0d, want all 0", uop_op, uop_raA, uop_raB, uop_rdest);
    end
  endtask

  task automatic test_lmul1();
    drive(1'b1, 3'b000, 5'd3, 5'd4, 5'd5);
    uop_ready = 1'b1;
    #2;
    n_checks++;
    if (stall_fetch !== 1'b0) begin n_fail++; $display("FAIL lmul1_stall_cap: got %b want 0", stall_fetch); end
    step();
    in_valid = 1'b0;
    #2;
    n_checks++;
    if ({uop_valid, uop_idx, uop_last, uop_raA, uop_raB, uop_rdest, stall_fetch} !==
        {1'b1, 3'd0, 1'b1, 5'd3, 5'd4, 5'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL lmul1_uop: got v=%b idx=%0d last=%b a=%0d b=%0d d=%0d stall=%b, want 1 0 1 3 4 5 0",
               uop_valid, uop_idx, uop_last, uop_raA, uop_raB, uop_rdest, stall_fetch);
    end
    step();
    #2;
    n_checks++;
    if (uop_valid !== 1'b0) begin n_fail++; $display("FAIL lmul1_end: valid got %b want 0", uop_valid); end
  endtask

  task automatic test_lmul4();
    drive(1'b1, 3'b010, 5'd8, 5'd12, 5'd16);
    uop_ready = 1'b1;
    #2;
    n_checks++;
    if (stall_fetch !== 1'b1) begin n_fail++; $display("FAIL lmul4_stall_cap: got %b want 1", stall_fetch); end
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_checks++;
      if ({uop_valid, uop_idx, uop_rdest, uop_raA, uop_last, stall_fetch} !==
          {1'b1, 3'(i), 5'(16 + i), 5'(8 + i), 1'(i == 3), 1'(i != 3)}) begin
        n_fail++;
        $display("FAIL lmul4_uop%0d: got v=%b idx=%0d d=%0d a=%0d last=%b stall=%b, want 1 %0d %0d %0d %0d %0d",
                 i, uop_valid, uop_idx, uop_rdest, uop_raA, uop_last, stall_fetch, i, 16 + i, 8 + i, i == 3, i != 3);
      end
      step();
    end
    #2;
    n_checks++;
    if ({uop_valid, stall_fetch} !== 2'b00) begin
      n_fail++; $display("FAIL lmul4_end: got v=%b stall=%b want 0 0", uop_valid, stall_fetch);
    end
  endtask

  task automatic test_stall_hold();
    logic [3:0] rdy_pat = 4'b1001;
    logic [2:0] idx_pat [4] = '{3'd0, 3'd1, 3'd1, 3'd1};
    drive(1'b1, 3'b001, 5'd2, 5'd4, 5'd6);
    uop_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      uop_ready = rdy_pat[3 - i];
      #2;
      n_checks++;
      if ({uop_valid, uop_idx, uop_rdest, in_ready} !== {1'b1, idx_pat[i], 5'(6 + int'(idx_pat[i])), 1'(i == 3)}) begin
        n_fail++;
        $display("FAIL hold_c%0d: got v=%b idx=%0d d=%0d rdy=%b, want 1 %0d %0d %0d",
                 i, uop_valid, uop_idx, uop_rdest, in_ready, idx_pat[i], 6 + idx_pat[i], i == 3);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 3'b001, 5'd0, 5'd2, 5'd4);
    uop_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    drive(1'b1, 3'b000, 5'd7, 5'd8, 5'd9);
    #2;
    n_checks++;
    if ({uop_valid, uop_last, in_ready} !== 3'b111) begin
      n_fail++; $display("FAIL b2b_last: got v=%b last=%b rdy=%b want 1 1 1", uop_valid, uop_last, in_ready);
    end
    step();
    in_valid = 1'b0;
    #2;
    n_checks++;
    if ({uop_valid, uop_idx, uop_raA, uop_rdest} !== {1'b1, 3'd0, 5'd7, 5'd9}) begin
      n_fail++;
      $display("FAIL b2b_next: got v=%b idx=%0d a=%0d d=%0d want 1 0 7 9", uop_valid, uop_idx, uop_raA, uop_rdest);
    end
    step();
  endtask

  task automatic test_wrap();
    drive(1'b1, 3'b011, 5'd0, 5'd8, 5'd30);
    uop_ready = 1'b1;
    step();
    in_valid = 1'b0;
`ifdef VGROUP_ALIGN_CHECK_EN
    #2;
    n_checks++;
    if ({illegal, uop_valid} !== 2'b10) begin
      n_fail++; $display("FAIL wrap_drop: got ill=%b v=%b want 1 0", illegal, uop_valid);
    end
    step();
    #2;
    n_checks++;
    if ({illegal, uop_valid} !== 2'b00) begin
      n_fail++; $display("FAIL wrap_pulse: got ill=%b v=%b want 0 0", illegal, uop_valid);
    end
`else
    for (int i = 0; i < 8; i++) begin
      #2;
      n_checks++;
      if ({uop_valid, uop_rdest, uop_last} !== {1'b1, 5'((30 + i) % 32), 1'(i == 7)}) begin
        n_fail++;
        $display("FAIL wrap_%0d: got v=%b d=%0d last=%b want 1 %0d %0d",
                 i, uop_valid, uop_rdest, uop_last, (30 + i) % 32, i == 7);
      end
      step();
    end
`endif
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 3'b011, 5'd0, 5'd8, 5'd16);
    uop_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    #2;
    n_checks++;
    if ({uop_valid, uop_idx, stall_fetch} !== {1'b1, 3'd2, 1'b1}) begin
      n_fail++; $display("FAIL mrst_pre: got v=%b idx=%0d stall=%b want 1 2 1", uop_valid, uop_idx, stall_fetch);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    n_checks++;
    if ({uop_valid, stall_fetch, in_ready, uop_idx, uop_last} !== {1'b0, 1'b0, 1'b1, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL mrst_post: got v=%b stall=%b rdy=%b idx=%0d last=%b want 0 0 1 0 0",
               uop_valid, stall_fetch, in_ready, uop_idx, uop_last);
    end
  endtask

  task automatic test_random();
    bit hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (!hold) begin
        in_valid    = ($urandom_range(0, 2) != 0);
        in_group_en = ($urandom_range(0, 3) != 0);
        in_lmul     = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        in_op       = 8'($urandom);
        in_raA      = 5'($urandom);
        in_raB      = 5'($urandom);
        in_rdest    = 5'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          in_raA &= 5'b11000; in_raB &= 5'b11000; in_rdest &= 5'b11000;
        end
      end
      uop_ready = ($urandom_range(0, 3) != 0);
      #2;
      n_checks++;
      if (uop_valid !== (q.size() > 0)) begin
        n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, uop_valid, q.size() > 0);
      end else if (q.size() > 0) begin
        n_checks++;
        if ({uop_op, uop_raA, uop_raB, uop_rdest, uop_idx, uop_last} !==
            {q[0].op, q[0].a, q[0].b, q[0].d, q[0].idx, q[0].last}) begin
          n_fail++;
          $display("FAIL rnd_uop c%0d: got op=%h a=%0d b=%0d d=%0d idx=%0d last=%b want %h %0d %0d %0d %0d %b",
                   c, uop_op, uop_raA, uop_raB, uop_rdest, uop_idx, uop_last,
                   q[0].op, q[0].a, q[0].b, q[0].d, q[0].idx, q[0].last);
        end
      end
      n_checks++;
      if ({in_ready, stall_fetch, illegal} !== {exp_in_ready(), exp_stall(), exp_illegal}) begin
        n_fail++;
        $display("FAIL rnd_ctrl c%0d: got rdy=%b stall=%b ill=%b want %b %b %b",
                 c, in_ready, stall_fetch, illegal, exp_in_ready(), exp_stall(), exp_illegal);
      end
      step();
      hold = in_valid && !last_take;
    end
    in_valid = 1'b0;
    uop_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    exp_illegal = 1'b0;
    test_reset();
    test_lmul1();
    test_lmul4();
    test_stall_hold();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vgroup_sequencer.md
Name: vgroup_sequencer

Overview:
- Registered issue stage directly upstream of the ALU operand/grouping path.
- Accepts one decoded vector instruction (base register numbers plus encoded LMUL) and expands it into LMUL back-to-back micro-ops, one per register of the group, each carrying per-register addresses and an element-group index.
- Owns the group counter and generates the fetch stall to IF1/IF2 while a group is in flight.

Parameters:
- REG_AW, 5, vector register address width (32 registers).
- OP_W, 8, opaque op/control payload width, passed through unchanged.
- CNT_W, 3, group index width (max LMUL 8).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decoded instruction valid.
- in_ready  out  1  sequencer can capture an instruction this cycle.
- in_op  in  OP_W  op payload.
- in_raA, in_raB, in_rdest  in  REG_AW each  base register numbers.
- in_lmul  in  3  encoded LMUL: 000=1, 001=2, 010=4, 011=8; 1xx reserved.
- in_group_en  in  1  grouping enabled; 0 forces a single micro-op.
- uop_valid  out  1  micro-op valid.
- uop_ready  in  1  downstream accepts the micro-op.
- uop_op  out  OP_W  captured payload.
- uop_raA, uop_raB, uop_rdest  out  REG_AW each  base + idx, modulo 2^REG_AW.
- uop_idx  out  CNT_W  index within the group.
- uop_last  out  1  final micro-op of the group.
- stall_fetch  out  1  hold IF1/IF2.
- illegal  out  1  one-cycle pulse on a rejected instruction (optional feature only; tied 0 otherwise).

Behaviour:
- States: IDLE, ISSUE.
- Reset (any state, including mid-group): state=IDLE, uop_valid=0, uop_idx=0, count target=0, uop_last=0, stall_fetch=0, illegal=0, all address/payload registers=0. Any in-flight group is discarded.
- in_ready = (state==IDLE) || (uop_valid && uop_ready && uop_last).
  - Allows back-to-back groups with no bubble.
- Capture: occurs on in_valid && in_ready.
  - Register payload and bases; set idx=0; set n = decoded LMUL.
  - n=1 if in_group_en=0 or in_lmul is reserved (1xx).
  - Next state is ISSUE with uop_valid=1 the following cycle. Latency from capture to first micro-op is 1 cycle.
- ISSUE:
  - uop_valid=1.
  - Outputs held stable while uop_valid && !uop_ready.
  - On accept with idx<n-1: idx increments.
  - On accept with idx==n-1 (uop_last): either capture a new instruction if in_valid (stay in ISSUE, idx=0), or go to IDLE with uop_valid=0.
- uop_last = (idx == n-1), combinational from registered state.
- Address arithmetic: base + idx, truncated to REG_AW bits. Wrap-around is allowed and unflagged: base 30, LMUL 4 yields 30, 31, 0, 1.
- stall_fetch:
  - Asserted when state==ISSUE && !(uop_valid && uop_ready && uop_last).
  - Also asserted when state==IDLE && in_valid is captured with n>1 (same cycle as capture).
  - Deasserted in IDLE otherwise.
- Simultaneous last-accept and new in_valid: the new capture wins; there is no IDLE cycle.
- in_valid while !in_ready: ignored. Upstream must hold it stable.

Optional Feature:
- Macro: VGROUP_ALIGN_CHECK_EN.
- With the macro defined:
  - At capture, if n>1 and any of in_raA, in_raB, in_rdest is not a multiple of n, the instruction is dropped.
  - On a drop: illegal pulses for 1 cycle, no micro-ops are issued, and the state stays (or becomes) IDLE.
  - A reserved in_lmul with in_group_en=1 is also dropped with an illegal pulse.
- Without the macro: no check; misaligned groups wrap as above; reserved LMUL is treated as 1; illegal is tied 0.

Decomposition:
- Shared package vgroup_pkg holds:
  - LMUL encoding constants (LMUL_1..LMUL_8).
  - The state enum (IDLE, ISSUE).
  - A decode function mapping in_lmul to a group count (0 for reserved).
- Sub-module vgroup_lmul_decode (combinational decode plus alignment check), instantiated once at capture.

Test Plan:
- LMUL=1 (000), raA=3, raB=4, rdest=5, uop_ready=1 → one micro-op at cycle+1 with idx 0, last=1, addresses 3/4/5; stall_fetch never asserts.
- LMUL=4 (010), bases 8/12/16, uop_ready=1 → 4 micro-ops on consecutive cycles with rdest 16, 17, 18, 19 and idx 0..3; last only on idx 3; stall_fetch high from capture until the last accept.
- LMUL=2, uop_ready toggled 1,0,0,1 → second micro-op held stable for 2 cycles; in_ready stays low until it is accepted.
- Back-to-back: LMUL=2, then a second instruction present during the last accept → second group's idx 0 appears the next cycle with no bubble.
- Wrap: rdest=30, LMUL=8, without the macro → rdest sequence 30, 31, 0..5. With VGROUP_ALIGN_CHECK_EN → illegal pulse and no micro-ops.
- rst asserted mid-group at idx 2 of LMUL 8 → next cycle uop_valid=0, stall_fetch=0, in_ready=1.
